// File: rtl/level_peak_hold_if.sv
// Section min/max handshake from the detector and the level/peak/bar
// handshake to the display side.
interface level_peak_hold_if #(
  parameter int width = 16
);
  localparam int bar_width = $clog2(width + 1);

  logic                 i_valid;
  logic                 i_ready;
  logic [width-1:0]     i_min_value;
  logic [width-1:0]     i_max_value;
  logic                 o_valid;
  logic                 o_ready;
  logic [width-1:0]     o_level;
  logic [width-1:0]     o_peak;
  logic [bar_width-1:0] o_bar;

  modport master (
    output i_valid, i_min_value, i_max_value, o_ready,
    input  i_ready, o_valid, o_level, o_peak, o_bar
  );

  modport slave (
    input  i_valid, i_min_value, i_max_value, o_ready,
    output i_ready, o_valid, o_level, o_peak, o_bar
  );
endinterface

// File: rtl/level_peak_hold.sv
// Section amplitude from a min/max pair, peak hold with linear decay,
// and a log2 bar index of the held peak for the level meter display.
module level_peak_hold #(
  parameter int width      = 16,
  parameter int hold_count = 8,
  parameter int decay_step = 256
) (
  input logic               clk,
  input logic               reset,
  level_peak_hold_if.slave  bus
);
  localparam int bar_width  = $clog2(width + 1);
  localparam int hold_width = $clog2(hold_count + 1);
  localparam logic [hold_width-1:0] hold_init    = hold_width'(hold_count);
  localparam logic [width-1:0]      decay_amount = width'(decay_step);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                state_reg;
  logic [width-1:0]      min_reg;
  logic [width-1:0]      max_reg;
  logic [width-1:0]      level_reg;
  logic [width-1:0]      peak_reg;
  logic [hold_width-1:0] hold_cnt_reg;
  logic [bar_width-1:0]  bar_reg;
  logic                  valid_reg;

  logic [width-1:0]      diff;
  logic [width-1:0]      amp_next;
  logic [width-1:0]      decayed;
  logic [width-1:0]      peak_next;
  logic [hold_width-1:0] hold_next;
  logic [bar_width-1:0]  bar_next;

  always_comb begin
    diff      = max_reg - min_reg;
    // An inverted pair (empty section) has no amplitude
    amp_next  = (max_reg >= min_reg) ? (diff >> 1) : '0;
    decayed   = (peak_reg > decay_amount) ? (peak_reg - decay_amount) : '0;
    peak_next = peak_reg;
    hold_next = hold_cnt_reg;
    if (amp_next >= peak_reg) begin
      peak_next = amp_next;
      hold_next = hold_init;
    end else if (hold_cnt_reg != '0) begin
      hold_next = hold_cnt_reg - hold_width'(1);
    end else begin
      peak_next = (amp_next > decayed) ? amp_next : decayed;
    end

    bar_next = '0;
    for (int i = 0; i < width; i++) begin
      if (peak_next[i]) bar_next = bar_width'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      min_reg      <= '0;
      max_reg      <= '0;
      level_reg    <= '0;
      peak_reg     <= '0;
      hold_cnt_reg <= '0;
      bar_reg      <= '0;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_valid) begin
            min_reg   <= bus.i_min_value;
            max_reg   <= bus.i_max_value;
            state_reg <= CALC;
          end
        end
        CALC: begin
          level_reg    <= amp_next;
          peak_reg     <= peak_next;
          hold_cnt_reg <= hold_next;
          bar_reg      <= bar_next;
          valid_reg    <= 1'b1;
          state_reg    <= OUT;
        end
        OUT: begin
          if (bus.o_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.i_ready = (state_reg == IDLE);
  assign bus.o_valid = valid_reg;
  assign bus.o_level = level_reg;
  assign bus.o_peak  = peak_reg;
  assign bus.o_bar   = bar_reg;
endmodule
